// File: rtl/medidor_pkg.sv
// Shared types and constants for the wave-period meter.
package medidor_pkg;

   typedef enum logic {
      ESPERA   = 1'b0,
      MIDIENDO = 1'b1
   } estado_t;

   localparam int unsigned CICLOS_POR_UNIDAD_DEF = 50000;
   localparam int unsigned PROMEDIO_PROFUNDIDAD  = 4;

   function automatic int unsigned ancho_prescaler(input int unsigned ciclos);
      return (ciclos > 1) ? $clog2(ciclos) : 1;
   endfunction

   localparam int unsigned PRESCALER_ANCHO_DEF = ancho_prescaler(CICLOS_POR_UNIDAD_DEF);

endpackage

// File: rtl/sincronizador_flanco.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector producing a one-cycle pulse.
module sincronizador_flanco (
   input  logic reloj_FPGA,
   input  logic reset_n,
   input  logic entrada,
   output logic flanco
);

   logic sinc1;
   logic sinc2;
   logic prev;

   always_ff @(posedge reloj_FPGA) begin
      if (!reset_n) begin
         sinc1 <= 1'b0;
         sinc2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sinc1 <= entrada;
         sinc2 <= sinc1;
         prev  <= sinc2;
      end
   end

   assign flanco = sinc2 & ~prev;

endmodule

// File: rtl/medidor_periodo_onda.sv
// Measures rising-edge-to-rising-edge period of an asynchronous wave in units
// of CICLOS_POR_UNIDAD clocks. Define MEDIDOR_PROMEDIO_EN for a 4-capture average.
module medidor_periodo_onda
   import medidor_pkg::*;
#(
   parameter int unsigned CANT_BITS         = 12,
   parameter int unsigned CICLOS_POR_UNIDAD = 50000
) (
   input  logic                 reloj_FPGA,
   input  logic                 reset_n,
   input  logic                 onda,
   output logic [CANT_BITS-1:0] periodo,
   output logic                 periodo_valido,
   output logic                 desborde
);

   localparam int unsigned          ANCHO_PRE       = ancho_prescaler(CICLOS_POR_UNIDAD);
   localparam logic [ANCHO_PRE-1:0] PRE_ULTIMO      = ANCHO_PRE'(CICLOS_POR_UNIDAD - 1);
   localparam logic [ANCHO_PRE-1:0] PRE_TRAS_FLANCO = (CICLOS_POR_UNIDAD > 1) ? ANCHO_PRE'(1) : '0;
   localparam logic [CANT_BITS-1:0] CUENTA_MAX      = '1;

   logic                 flanco;
   logic                 tick;
   logic [ANCHO_PRE-1:0] prescaler;
   logic [ANCHO_PRE-1:0] prescaler_sig;
   logic [CANT_BITS-1:0] cuenta;
   logic [CANT_BITS-1:0] cuenta_sig;
   estado_t              estado;
   estado_t              estado_sig;

   logic                 cap_valido;
   logic                 cap_desborde;
   logic [CANT_BITS-1:0] cap_valor;

   sincronizador_flanco u_sincronizador (
      .reloj_FPGA (reloj_FPGA),
      .reset_n    (reset_n),
      .entrada    (onda),
      .flanco     (flanco)
   );

   always_ff @(posedge reloj_FPGA) begin
      if (!reset_n) begin
         estado    <= ESPERA;
         prescaler <= '0;
         cuenta    <= '0;
      end else begin
         estado    <= estado_sig;
         prescaler <= prescaler_sig;
         cuenta    <= cuenta_sig;
      end
   end

   // The flanco cycle itself is prescaler count 0, so a period of P clocks
   // accumulates exactly floor(P/CICLOS_POR_UNIDAD) ticks before the next flanco.
   always_comb begin
      tick          = (prescaler == PRE_ULTIMO);
      estado_sig    = estado;
      prescaler_sig = tick ? '0 : prescaler + ANCHO_PRE'(1);
      cuenta_sig    = tick ? cuenta + CANT_BITS'(1) : cuenta;
      cap_valido    = 1'b0;
      cap_desborde  = 1'b0;
      cap_valor     = cuenta;

      if (flanco) begin
         prescaler_sig = PRE_TRAS_FLANCO;
         cuenta_sig    = '0;
         estado_sig    = MIDIENDO;
         cap_valido    = (estado == MIDIENDO);
      end else if (estado == MIDIENDO && tick && cuenta == CUENTA_MAX) begin
         prescaler_sig = '0;
         cuenta_sig    = '0;
         estado_sig    = ESPERA;
         cap_valido    = 1'b1;
         cap_desborde  = 1'b1;
         cap_valor     = CUENTA_MAX;
      end
   end

`ifdef MEDIDOR_PROMEDIO_EN
   localparam int unsigned ANCHO_IDX  = $clog2(PROMEDIO_PROFUNDIDAD);
   localparam int unsigned ANCHO_SUMA = CANT_BITS + ANCHO_IDX;

   logic [PROMEDIO_PROFUNDIDAD-1:0][CANT_BITS-1:0] historia;
   logic [PROMEDIO_PROFUNDIDAD-1:0][CANT_BITS-1:0] historia_sig;
   logic                                           historia_llena;
   logic                                           llena_sig;
   logic                                           pend_valido;
   logic                                           pend_desborde;
   logic [ANCHO_SUMA-1:0]                          suma;

   always_comb begin
      historia_sig = historia;
      llena_sig    = historia_llena;
      if (cap_valido) begin
         if (cap_desborde) begin
            historia_sig = '0;
            llena_sig    = 1'b0;
         end else if (!historia_llena) begin
            historia_sig = {PROMEDIO_PROFUNDIDAD{cap_valor}};
            llena_sig    = 1'b1;
         end else begin
            historia_sig = {historia[PROMEDIO_PROFUNDIDAD-2:0], cap_valor};
         end
      end
   end

   always_comb begin
      suma = '0;
      for (int unsigned i = 0; i < PROMEDIO_PROFUNDIDAD; i++)
         suma = suma + ANCHO_SUMA'(historia[ANCHO_IDX'(i)]);
   end

   // History settles one cycle after the capture; the average is registered the cycle after.
   always_ff @(posedge reloj_FPGA) begin
      if (!reset_n) begin
         historia       <= '0;
         historia_llena <= 1'b0;
         pend_valido    <= 1'b0;
         pend_desborde  <= 1'b0;
         periodo        <= '0;
         periodo_valido <= 1'b0;
         desborde       <= 1'b0;
      end else begin
         historia       <= historia_sig;
         historia_llena <= llena_sig;
         pend_valido    <= cap_valido;
         pend_desborde  <= cap_desborde;
         periodo_valido <= pend_valido;
         if (pend_valido) begin
            desborde <= pend_desborde;
            periodo  <= pend_desborde ? CUENTA_MAX : suma[ANCHO_SUMA-1:ANCHO_IDX];
         end
      end
   end
`else
   always_ff @(posedge reloj_FPGA) begin
      if (!reset_n) begin
         periodo        <= '0;
         periodo_valido <= 1'b0;
         desborde       <= 1'b0;
      end else begin
         periodo_valido <= cap_valido;
         if (cap_valido) begin
            periodo  <= cap_valor;
            desborde <= cap_desborde;
         end
      end
   end
`endif

endmodule
